softmax_max_sub: RTL and testbench

SOFTMAX_MAX_SUB -- requirements
Module: softmax_max_sub

---
 rtl/softmax_max_sub_if.sv | 44 ++++
 rtl/softmax_max_sub.sv | 142 ++++++++++++++
 tb/tb_softmax_max_sub.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/softmax_max_sub_if.sv
`default_nettype none
// ============================================================================
// Module      : softmax_max_sub_if
// Description : Stream bundle between the score source, the max-subtract
//               stage and the downstream exp lookup.
//               Input side : ivalid, iready, bin_in
//                            (signed 8-bit score)
//               Output side: ovalid, oready, bin_out
//                            (signed 8-bit score minus the row max),
//                            olast (last element of a row)
//               Modports   : slave  - the max-subtract stage
//                            master - the environment that drives it
// Revision    : 1.0 - initial release
// ============================================================================
interface softmax_max_sub_if;
    logic       ivalid;
    logic       iready;
    logic [7:0] bin_in;
    logic       ovalid;
    logic       oready;
    logic [7:0] bin_out;
    logic       olast;

    modport slave (
        input  ivalid,
        input  bin_in,
        input  oready,
        output iready,
        output ovalid,
        output bin_out,
        output olast
    );

    modport master (
        output ivalid,
        output bin_in,
        output oready,
        input  iready,
        input  ovalid,
        input  bin_out,
        input  olast
    );
endinterface
`default_nettype wire

// File: rtl/softmax_max_sub.sv
`default_nettype none
// ============================================================================
// Module      : softmax_max_sub
// Description : Buffers one row of ROW_LEN signed 8-bit scores while
//               tracking the running maximum. It then streams every
//               buffered score minus the row maximum (always <= 0), with
//               saturation at -128, one element per cycle.
// Ports       : clock  - single clock, rising edge
//               resetn - asynchronous active-low reset
//               bus    - softmax_max_sub_if.slave
//                        (ivalid/iready/bin_in in,
//                         ovalid/oready/bin_out/olast out)
// Parameters  : ROW_LEN - elements per row, 2..64
// Revision    : 1.0 - initial release
// ============================================================================
module softmax_max_sub #(
    parameter int ROW_LEN = 16
) (
    input  wire logic         clock,
    input  wire logic         resetn,
    softmax_max_sub_if.slave  bus
);

    localparam int                CNT_W      = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam logic [CNT_W-1:0]  C_LAST_IDX = CNT_W'(ROW_LEN - 1);

    generate
        if (ROW_LEN < 2 || ROW_LEN > 64) begin : g_row_len_check
            $error("softmax_max_sub: ROW_LEN must be within 2..64");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic [7:0]         r_max;
    logic [7:0]         r_bin_out;
    logic               r_olast;
    logic [7:0]         r_buf [ROW_LEN];

    logic               w_iready;
    logic               w_ovalid;
    logic               w_in_xfer;
    logic               w_in_last;
    logic               w_out_xfer;
    logic               w_out_last;
    logic [7:0]         w_row_max;
    logic [CNT_W-1:0]   w_rd_nxt;

    // Difference x - m is formed in 9 bits so it cannot wrap; since m is the
    // row max the result lies in [-255, 0]. Values below -128 have bit 8 set
    // and bit 7 clear, and clamp to -128.
    function automatic logic [7:0] sat_diff(input logic [7:0] x, input logic [7:0] m);
        logic [8:0] d;
        d = {x[7], x} - {m[7], m};
        return (d[8] & ~d[7]) ? 8'h80 : d[7:0];
    endfunction

    // iready is gated by resetn so it stays low for the whole reset window
    // and rises as soon as reset is released.
    assign w_iready   = (r_state == S_FILL) & resetn;
    assign w_ovalid   = (r_state == S_DRAIN);
    assign w_in_xfer  = bus.ivalid & w_iready;
    assign w_in_last  = w_in_xfer & (r_wr_cnt == C_LAST_IDX);
    assign w_out_xfer = w_ovalid & bus.oready;
    assign w_out_last = w_out_xfer & r_olast;
    assign w_rd_nxt   = r_rd_cnt + CNT_W'(1);

    // Running max including the element being accepted this cycle; the
    // first element of a row loads it unconditionally.
    always_comb begin
        w_row_max = r_max;
        if (r_wr_cnt == '0) begin
            w_row_max = bus.bin_in;
        end else if ($signed(bus.bin_in) > $signed(r_max)) begin
            w_row_max = bus.bin_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL:  if (w_in_last)  w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_out_last) w_state_nxt = S_FILL;
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_max     <= 8'h00;
            r_bin_out <= 8'h00;
            r_olast   <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                r_max    <= w_row_max;
                r_wr_cnt <= w_in_last ? '0 : r_wr_cnt + CNT_W'(1);
            end
            if (w_in_last) begin
                // Element 0 is already in the buffer; the max must include
                // the element arriving on this same edge.
                r_rd_cnt  <= '0;
                r_bin_out <= sat_diff(r_buf[0], w_row_max);
                r_olast   <= 1'b0;
            end else if (w_out_xfer && !r_olast) begin
                r_rd_cnt  <= w_rd_nxt;
                r_bin_out <= sat_diff(r_buf[w_rd_nxt], r_max);
                r_olast   <= (w_rd_nxt == C_LAST_IDX);
            end
        end
    end

    // Row storage carries no reset; every entry is written before it is read.
    always_ff @(posedge clock) begin
        if (w_in_xfer) begin
            r_buf[r_wr_cnt] <= bus.bin_in;
        end
    end

    assign bus.iready  = w_iready;
    assign bus.ovalid  = w_ovalid;
    assign bus.bin_out = r_bin_out;
    assign bus.olast   = r_olast;

endmodule
`default_nettype wire

// File: tb/tb_softmax_max_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_softmax_max_sub
// Description : Scoreboard bench for softmax_max_sub with ROW_LEN = 4.
//               Accepted inputs are collected per row; a complete row is
//               turned into expected outputs by a reference model (row max,
//               plain integer subtraction, clamp at -128) and queued. An
//               independent monitor pops and compares on every output
//               transfer, and also checks hold-while-stalled, iready low
//               while draining and the one-cycle first-output latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_softmax_max_sub;

    localparam int ROW_LEN = 4;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    softmax_max_sub_if bus();

    softmax_max_sub #(.ROW_LEN(ROW_LEN)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_acc_cyc = -100;
    int         row_acc[$];
    logic [8:0] exp_q[$];
    logic       rand_done;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: subtract the row maximum from each element, clamp at -128.
    function automatic void model_row();
        int m;
        int d;
        logic [7:0] b;
        logic l;
        m = row_acc[0];
        foreach (row_acc[i]) if (row_acc[i] > m) m = row_acc[i];
        foreach (row_acc[i]) begin
            d = row_acc[i] - m;
            if (d < -128) d = -128;
            b = d[7:0];
            l = (i == ROW_LEN - 1);
            exp_q.push_back({l, b});
        end
    endfunction

    // Input-side observer: inputs are stable from posedge+1, so what is seen
    // at the negedge is what transfers on the following rising edge.
    always @(negedge clock) begin
        if (!resetn) begin
            row_acc.delete();
            exp_q.delete();
        end else if (bus.ivalid && bus.iready) begin
            row_acc.push_back(int'($signed(bus.bin_in)));
            last_acc_cyc = cyc;
            if (row_acc.size() == ROW_LEN) begin
                model_row();
                row_acc.delete();
            end
        end
    end

    // Output monitor.
    logic       prev_valid = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_bin   = 8'h00;
    logic       prev_last  = 1'b0;
    logic [8:0] e;

    always @(negedge clock) begin
        if (!resetn) begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (bus.ovalid) begin
                check("iready_low_in_drain", bus.iready, 0);
                if (!prev_valid) check("first_ovalid_latency", cyc, last_acc_cyc + 1);
                if (prev_stall) begin
                    check("hold_bin_out", bus.bin_out, prev_bin);
                    check("hold_olast", bus.olast, prev_last);
                end
                if (bus.oready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_output: got 0x%0h, expected no output", bus.bin_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", bus.bin_out, e[7:0]);
                        check("out_last", bus.olast, e[8]);
                    end
                end
            end
            prev_valid = bus.ovalid;
            prev_stall = bus.ovalid && !bus.oready;
            prev_bin   = bus.bin_out;
            prev_last  = bus.olast;
        end
    end

    task automatic send(input int v);
        int guard;
        guard = 0;
        forever begin
            @(posedge clock);
            #1;
            bus.ivalid = 1'b1;
            if (bus.iready) begin
                bus.bin_in = 8'(v);
                break;
            end
            bus.bin_in = 8'($urandom);
            guard++;
            if (guard > 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: iready stayed 0, expected 1 within 200 cycles");
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            bus.ivalid = 1'b0;
            bus.bin_in = 8'($urandom);
        end
    endtask

    task automatic send_row(input int v[ROW_LEN]);
        foreach (v[i]) send(v[i]);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 || bus.ovalid || row_acc.size() != 0) begin
            @(negedge clock);
            guard++;
            if (guard > 500) begin
                n_cmp++;
                n_fail++;
                $display("FAIL drain_timeout: %0d outputs pending, expected 0", exp_q.size());
                break;
            end
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_ovalid", bus.ovalid, 0);
        check("rst_bin_out", bus.bin_out, 8'h00);
        check("rst_olast", bus.olast, 0);
        check("rst_iready", bus.iready, 0);
    endtask

    function automatic int rand_score();
        case ($urandom_range(0, 5))
            0:       return -128;
            1:       return 127;
            default: return int'($signed(8'($urandom)));
        endcase
    endfunction

    initial begin
        resetn     = 1'b0;
        bus.ivalid = 1'b0;
        bus.bin_in = 8'h00;
        bus.oready = 1'b1;
        rand_done  = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs();
        @(posedge clock);
        #1 resetn = 1'b1;
        @(negedge clock);
        check("iready_after_reset", bus.iready, 1);

        // Basic rows, saturation and all-equal minimum.
        send_row('{10, -5, 30, 30});
        idle(1);
        wait_drain();
        send_row('{127, -128, 0, 0});
        idle(1);
        wait_drain();
        send_row('{-128, -128, -128, -128});
        idle(1);
        wait_drain();

        // Downstream stall right after the first output.
        bus.oready = 1'b0;
        send_row('{1, 2, 3, 4});
        idle(1);
        repeat (3) begin
            @(negedge clock);
            check("stall_value", bus.bin_out, 8'hFD);
        end
        @(posedge clock);
        #1 bus.oready = 1'b1;
        wait_drain();

        // ivalid held high across two rows; DUT must backpressure in DRAIN.
        send_row('{-3, 100, -100, 50});
        send_row('{0, -1, -128, 127});
        idle(1);
        wait_drain();

        // Reset after two accepted inputs discards the partial row.
        send(100);
        send(90);
        @(posedge clock);
        #1;
        resetn     = 1'b0;
        bus.ivalid = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_outputs();
        @(posedge clock);
        #1 resetn = 1'b1;
        send_row('{5, 6, 7, 8});
        idle(1);
        wait_drain();

        // Reset in the middle of DRAIN.
        bus.oready = 1'b0;
        send_row('{rand_score(), rand_score(), rand_score(), rand_score()});
        idle(1);
        @(negedge clock);
        check("ovalid_before_drain_reset", bus.ovalid, 1);
        @(posedge clock);
        #1 resetn = 1'b0;
        @(negedge clock);
        check_reset_outputs();
        @(posedge clock);
        #1;
        resetn     = 1'b1;
        bus.oready = 1'b1;
        send_row('{-20, 60, 60, -70});
        idle(1);
        wait_drain();

        // Randomised rows with input gaps and random downstream backpressure.
        fork
            begin
                for (int r = 0; r < 40; r++) begin
                    for (int k = 0; k < ROW_LEN; k++) begin
                        idle($urandom_range(0, 2) == 0 ? 1 : 0);
                        send(rand_score());
                    end
                end
                idle(1);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clock);
                    #1 bus.oready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(posedge clock);
        #1 bus.oready = 1'b1;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
